// File: rtl/vector_pkg.sv
// Shared definitions for the lane-parallel vector ALU.
//   - VLEN default, op / source-select / element-width encodings
//   - FSM state encoding
//   - sew_mask(): low-bit mask for an element width
package vector_pkg;

    localparam int unsigned VLEN_DEFAULT = 128;

    localparam logic [2:0] VOP_ADD = 3'd0;
    localparam logic [2:0] VOP_SUB = 3'd1;
    localparam logic [2:0] VOP_AND = 3'd2;
    localparam logic [2:0] VOP_OR  = 3'd3;
    localparam logic [2:0] VOP_XOR = 3'd4;
    localparam logic [2:0] VOP_SLL = 3'd5;
    localparam logic [2:0] VOP_SRL = 3'd6;
    localparam logic [2:0] VOP_MUL = 3'd7;

    localparam logic [1:0] VSRC_VV = 2'd0;
    localparam logic [1:0] VSRC_VX = 2'd1;
    localparam logic [1:0] VSRC_VI = 2'd2;

    localparam logic [2:0] VSEW_8  = 3'd0;
    localparam logic [2:0] VSEW_16 = 3'd1;
    localparam logic [2:0] VSEW_32 = 3'd2;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } vstate_e;

    function automatic logic [31:0] sew_mask(input logic [1:0] sew);
        logic [31:0] m;
        case ({1'b0, sew})
            VSEW_8:  m = 32'h0000_00FF;
            VSEW_16: m = 32'h0000_FFFF;
            default: m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/vector_lane.sv
// Combinational single-element ALU.
//   op  : operation code (VOP_*)
//   sew : element width code (0=8, 1=16, 2=32)
//   a   : 32-bit slot holding the vs2 element in its low SEW bits
//   b   : second operand in its low SEW bits
//   y   : result, zero above SEW
module vector_lane
    import vector_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  sew,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    logic [31:0] m;
    logic [31:0] am;
    logic [31:0] bm;
    logic [4:0]  shamt;
    logic [31:0] raw;

    always_comb begin
        m  = sew_mask(sew);
        // Upper slot bits belong to neighbouring elements; clear them first.
        am = a & m;
        bm = b & m;
        case ({1'b0, sew})
            VSEW_8:  shamt = {2'b00, bm[2:0]};
            VSEW_16: shamt = {1'b0, bm[3:0]};
            default: shamt = bm[4:0];
        endcase
        case (op)
            VOP_ADD: raw = am + bm;
            VOP_SUB: raw = am - bm;
            VOP_AND: raw = am & bm;
            VOP_OR:  raw = am | bm;
            VOP_XOR: raw = am ^ bm;
            VOP_SLL: raw = am << shamt;
            VOP_SRL: raw = am >> shamt;
            VOP_MUL: raw = am * bm;
            default: raw = '0;
        endcase
        y = raw & m;
    end

endmodule

// File: rtl/vector_lane_alu.sv
// Multi-cycle lane-parallel integer vector ALU.
//   SYS_clk, SYS_reset (async, active-low)
//   start/kill         : launch (sampled in idle) / abort
//   op, src_sel        : operation and second-operand source
//   vs1_data, vs2_data, vd_old, mask_v0, vm, scalar, imm5 : operands
//   vsew, vlmul, vl, vstart : vector configuration
//   busy, done, error, result : status and new vd value
module vector_lane_alu
    import vector_pkg::*;
#(
    parameter int unsigned VLEN  = VLEN_DEFAULT,
    parameter int unsigned LANES = 2,
    parameter int unsigned ELEN  = 32
) (
    input  logic            SYS_clk,
    input  logic            SYS_reset,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      op,
    input  logic [1:0]      src_sel,
    input  logic [VLEN-1:0] vs1_data,
    input  logic [VLEN-1:0] vs2_data,
    input  logic [VLEN-1:0] vd_old,
    input  logic [VLEN-1:0] mask_v0,
    input  logic            vm,
    input  logic [31:0]     scalar,
    input  logic [4:0]      imm5,
    input  logic [2:0]      vsew,
    input  logic [2:0]      vlmul,
    input  logic [31:0]     vl,
    input  logic [31:0]     vstart,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic [VLEN-1:0] result
);

    // Legal vl never exceeds VLEN/8, so idx/vl/vstart fit with headroom.
    localparam int unsigned IW = $clog2(VLEN / 8) + 2;

    vstate_e         state_q;
    logic [VLEN-1:0] vs1_q, vs2_q, mask_q, acc_q, result_q;
    logic            vm_q, err_q;
    logic [31:0]     scalar_q;
    logic [4:0]      imm5_q;
    logic [1:0]      sew_q, src_q;
    logic [2:0]      op_q;
    logic [IW-1:0]   vl_q, vstart_q, idx_q;

    logic [31:0]     max_vl;
    logic            illegal, empty;
    logic [VLEN-1:0] acc_run;
    logic [31:0]     lane_res [LANES];
    logic [31:0]     lane_off [LANES];
    logic            lane_en  [LANES];

    assign max_vl  = 32'(VLEN) >> (32'd3 + 32'(vsew));
    assign illegal = (vsew > VSEW_32) || (vlmul != 3'd0) || (src_sel == 2'd3) || (vl > max_vl);
    assign empty   = (vstart >= vl);

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic [IW-1:0]   e;
        logic [ELEN-1:0] a_slot, b_vv, opnd;
        logic            mask_bit;

        assign e        = idx_q + IW'(j);
        assign lane_off[j] = 32'(e) << (32'd3 + 32'(sew_q));
        assign a_slot   = ELEN'(vs2_q >> lane_off[j]);
        assign b_vv     = ELEN'(vs1_q >> lane_off[j]);
        assign mask_bit = |(mask_q & (VLEN'(1) << e));
        assign lane_en[j] = (e >= vstart_q) && (e < vl_q) && (vm_q || mask_bit);

        always_comb begin
            case (src_q)
                VSRC_VV: opnd = b_vv;
                VSRC_VX: opnd = scalar_q;
                VSRC_VI: opnd = {{27{imm5_q[4]}}, imm5_q};
                default: opnd = b_vv;
            endcase
        end

        vector_lane u_lane (
            .op  (op_q),
            .sew (sew_q),
            .a   (a_slot),
            .b   (opnd),
            .y   (lane_res[j])
        );
    end

    always_comb begin
        acc_run = acc_q;
        for (int j = 0; j < LANES; j++) begin
            if (lane_en[j]) begin
                acc_run = (acc_run & ~(VLEN'(sew_mask(sew_q)) << lane_off[j]))
                        | (VLEN'(lane_res[j]) << lane_off[j]);
            end
        end
    end

    always_ff @(posedge SYS_clk or negedge SYS_reset) begin
        if (!SYS_reset) begin
            state_q  <= StIdle;
            vs1_q    <= '0;
            vs2_q    <= '0;
            mask_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            vm_q     <= 1'b0;
            err_q    <= 1'b0;
            scalar_q <= '0;
            imm5_q   <= '0;
            sew_q    <= '0;
            src_q    <= '0;
            op_q     <= '0;
            vl_q     <= '0;
            vstart_q <= '0;
            idx_q    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        vs1_q    <= vs1_data;
                        vs2_q    <= vs2_data;
                        mask_q   <= mask_v0;
                        acc_q    <= vd_old;
                        vm_q     <= vm;
                        err_q    <= illegal;
                        scalar_q <= scalar;
                        imm5_q   <= imm5;
                        sew_q    <= vsew[1:0];
                        src_q    <= src_sel;
                        op_q     <= op;
                        vl_q     <= IW'(vl);
                        vstart_q <= IW'(vstart);
                        idx_q    <= IW'(vstart);
                        state_q  <= (illegal || empty) ? StDone : StRun;
                    end
                end
                StRun: begin
                    if (kill) begin
                        state_q <= StIdle;
                    end else begin
                        acc_q <= acc_run;
                        idx_q <= idx_q + IW'(LANES);
                        if (idx_q + IW'(LANES) >= vl_q) state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    // A kill here suppresses the pulse, so the old result stays.
                    if (!kill) result_q <= acc_q;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StDone) && !kill;
    assign error  = done && err_q;
    assign result = done ? acc_q : result_q;

endmodule

// File: tb/tb_vector_lane_alu.sv
module tb_vector_lane_alu;

    localparam int unsigned VLEN  = 128;
    localparam int unsigned LANES = 2;

    logic            SYS_clk = 1'b0;
    logic            SYS_reset;
    logic            start, kill, vm;
    logic [2:0]      op, vsew, vlmul;
    logic [1:0]      src_sel;
    logic [VLEN-1:0] vs1_data, vs2_data, vd_old, mask_v0;
    logic [31:0]     scalar, vl, vstart;
    logic [4:0]      imm5;
    logic            busy, done, error;
    logic [VLEN-1:0] result;

    int checks = 0;
    int errors = 0;

    vector_lane_alu #(.VLEN(VLEN), .LANES(LANES), .ELEN(32)) dut (
        .SYS_clk   (SYS_clk),
        .SYS_reset (SYS_reset),
        .start     (start),
        .kill      (kill),
        .op        (op),
        .src_sel   (src_sel),
        .vs1_data  (vs1_data),
        .vs2_data  (vs2_data),
        .vd_old    (vd_old),
        .mask_v0   (mask_v0),
        .vm        (vm),
        .scalar    (scalar),
        .imm5      (imm5),
        .vsew      (vsew),
        .vlmul     (vlmul),
        .vl        (vl),
        .vstart    (vstart),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .result    (result)
    );

    always #5 SYS_clk = ~SYS_clk;

    task automatic set_defaults();
        start = 0; kill = 0; vm = 1; op = 3'd0; src_sel = 2'd0;
        vsew = 3'd2; vlmul = 3'd0; vl = 0; vstart = 0;
        vs1_data = '0; vs2_data = '0; vd_old = '0; mask_v0 = '0;
        scalar = 0; imm5 = 0;
    endtask

    // Pulse start for one edge; returns #1 after the start edge (cycle 1).
    task automatic launch();
        @(negedge SYS_clk);
        start = 1;
        @(posedge SYS_clk);
        #1;
        start = 0;
    endtask

    // Cycle number (1 = first cycle after start edge) at which done is seen, or -1.
    task automatic wait_done(output int cyc, output int busy_cnt);
        cyc = -1;
        busy_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            if (busy) busy_cnt++;
            if (done) begin
                cyc = k;
                break;
            end
            @(posedge SYS_clk);
            #1;
        end
    endtask

    task automatic test_reset();
        set_defaults();
        SYS_reset = 0;
        #12;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", error); end
        checks++; if (result !== '0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
        @(negedge SYS_clk);
        SYS_reset = 1;
    endtask

    task automatic run_add_vv32(input string tag);
        int cyc, bc;
        set_defaults();
        op = 3'd0; src_sel = 2'd0; vsew = 3'd2; vl = 4; vstart = 0; vm = 1;
        vs2_data = {32'd4, 32'd3, 32'd2, 32'd1};
        vs1_data = {32'd40, 32'd30, 32'd20, 32'd10};
        vd_old   = {4{32'h5555_5555}};
        launch();
        wait_done(cyc, bc);
        checks++; if (cyc !== 3) begin errors++; $display("FAIL %s_latency: got %0d expected 3", tag, cyc); end
        checks++; if (bc !== 3) begin errors++; $display("FAIL %s_busy_cycles: got %0d expected 3", tag, bc); end
        checks++; if (result !== {32'd44, 32'd33, 32'd22, 32'd11}) begin
            errors++; $display("FAIL %s_result: got %h expected %h", tag, result, {32'd44, 32'd33, 32'd22, 32'd11});
        end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL %s_error: got %b expected 0", tag, error); end
        @(posedge SYS_clk);
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL %s_idle_after: got busy=%b done=%b expected 0 0", tag, busy, done);
        end
        checks++; if (result !== {32'd44, 32'd33, 32'd22, 32'd11}) begin
            errors++; $display("FAIL %s_result_held: got %h expected %h", tag, result, {32'd44, 32'd33, 32'd22, 32'd11});
        end
    endtask

    task automatic test_add();
        run_add_vv32("add");
    endtask

    task automatic test_masked_sub();
        int cyc, bc;
        set_defaults();
        op = 3'd1; src_sel = 2'd1; vsew = 3'd0; vl = 5; vm = 0;
        mask_v0 = 128'h15; scalar = 1;
        vs2_data = {16{8'h10}};
        vd_old   = {16{8'hAA}};
        launch();
        wait_done(cyc, bc);
        checks++; if (cyc !== 4) begin errors++; $display("FAIL msub_latency: got %0d expected 4", cyc); end
        checks++; if (result !== 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AA0F_AA0F_AA0F) begin
            errors++; $display("FAIL msub_result: got %h expected %h", result, 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AA0F_AA0F_AA0F);
        end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL msub_error: got %b expected 0", error); end
        @(posedge SYS_clk);
        #1;
    endtask

    task automatic test_empty();
        int cyc, bc;
        set_defaults();
        vsew = 3'd2; vl = 3; vstart = 3;
        vs1_data = {4{32'h1}}; vs2_data = {4{32'h2}};
        vd_old = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        launch();
        wait_done(cyc, bc);
        checks++; if (cyc !== 1) begin errors++; $display("FAIL empty_latency: got %0d expected 1", cyc); end
        checks++; if (result !== 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210) begin
            errors++; $display("FAIL empty_result: got %h expected vd_old", result);
        end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL empty_error: got %b expected 0", error); end
        @(posedge SYS_clk);
        #1;
    endtask

    task automatic test_illegal();
        int cyc, bc;
        for (int t = 0; t < 3; t++) begin
            set_defaults();
            vl = 2;
            vs1_data = {4{32'h7}}; vs2_data = {4{32'h9}};
            vd_old = {4{32'hCAFE_0000 + 32'(t)}};
            if (t == 0) vsew = 3'd3;
            if (t == 1) vlmul = 3'd1;
            if (t == 2) vl = 5;
            launch();
            wait_done(cyc, bc);
            checks++; if (cyc !== 1) begin errors++; $display("FAIL illegal%0d_latency: got %0d expected 1", t, cyc); end
            checks++; if (error !== 1'b1) begin errors++; $display("FAIL illegal%0d_error: got %b expected 1", t, error); end
            checks++; if (result !== {4{32'hCAFE_0000 + 32'(t)}}) begin
                errors++; $display("FAIL illegal%0d_result: got %h expected %h", t, result, {4{32'hCAFE_0000 + 32'(t)}});
            end
            @(posedge SYS_clk);
            #1;
        end
    endtask

    task automatic test_mul_wrap();
        int cyc, bc;
        set_defaults();
        op = 3'd7; src_sel = 2'd2; vsew = 3'd1; vl = 1; imm5 = 5'h1E;
        vs2_data = 128'h1234;
        launch();
        wait_done(cyc, bc);
        checks++; if (cyc !== 2) begin errors++; $display("FAIL mul_latency: got %0d expected 2", cyc); end
        checks++; if (result !== 128'hDB98) begin errors++; $display("FAIL mul_result: got %h expected %h", result, 128'hDB98); end
        @(posedge SYS_clk);
        #1;
        set_defaults();
        op = 3'd0; src_sel = 2'd0; vsew = 3'd0; vl = 1;
        vs2_data = 128'hFF; vs1_data = 128'h01; vd_old = {16{8'h77}};
        launch();
        wait_done(cyc, bc);
        checks++; if (cyc !== 2) begin errors++; $display("FAIL wrap_latency: got %0d expected 2", cyc); end
        checks++; if (result !== {{15{8'h77}}, 8'h00}) begin
            errors++; $display("FAIL wrap_result: got %h expected %h", result, {{15{8'h77}}, 8'h00});
        end
        @(posedge SYS_clk);
        #1;
    endtask

    task automatic test_shift_xor();
        int cyc, bc;
        set_defaults();
        op = 3'd5; src_sel = 2'd1; vsew = 3'd2; vl = 1; scalar = 33;
        vs2_data = 128'h8000_0001;
        launch();
        wait_done(cyc, bc);
        checks++; if (result !== 128'h2) begin errors++; $display("FAIL sll_result: got %h expected %h", result, 128'h2); end
        @(posedge SYS_clk);
        #1;
        set_defaults();
        op = 3'd4; src_sel = 2'd2; vsew = 3'd2; vl = 1; imm5 = 5'h0F;
        vs2_data = 128'hF0;
        launch();
        wait_done(cyc, bc);
        checks++; if (result !== 128'hFF) begin errors++; $display("FAIL xor_result: got %h expected %h", result, 128'hFF); end
        @(posedge SYS_clk);
        #1;
    endtask

    task automatic test_async_reset();
        set_defaults();
        op = 3'd0; vsew = 3'd0; vl = 16;
        vs1_data = {16{8'h01}}; vd_old = {16{8'h33}};
        launch();
        #3;
        SYS_reset = 0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL areset_done: got %b expected 0", done); end
        checks++; if (result !== '0) begin errors++; $display("FAIL areset_result: got %h expected 0", result); end
        @(negedge SYS_clk);
        SYS_reset = 1;
    endtask

    task automatic test_kill();
        int seen = 0;
        set_defaults();
        op = 3'd0; vsew = 3'd0; vl = 16;
        vs1_data = {16{8'h01}}; vd_old = {16{8'h33}};
        launch();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL kill_busy_run: got %b expected 1", busy); end
        kill = 1;
        @(posedge SYS_clk);
        #1;
        kill = 0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL kill_idle: got busy=%b expected 0", busy); end
        for (int k = 0; k < 12; k++) begin
            if (done) seen++;
            @(posedge SYS_clk);
            #1;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL kill_no_done: got %0d done cycles expected 0", seen); end
        checks++; if (result !== '0) begin errors++; $display("FAIL kill_result: got %h expected 0", result); end
        run_add_vv32("restart");
    endtask

    initial begin
        test_reset();
        test_add();
        test_masked_sub();
        test_empty();
        test_illegal();
        test_mul_wrap();
        test_shift_xor();
        test_async_reset();
        test_kill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
